imu_fifo_arbiter: RTL and testbench

Round-robin write-side arbiter that shares one IMU buffer-manager FIFO among `N_SRC` sample producers (per-axis or per-sensor IMU front ends). It grants the FIFO write port to one source at a time and holds that grant for a burst of up to `MAX_BURST` beats. Each accepted sample is tagged with its source ID and writes are throttled on FIFO `full`. It sits between the IMU capture stages and the FIFO's `write_en`/`data_in`/`full` port.

---
 rtl/imu_fifo_arbiter.sv | 129 ++++++++++++
 tb/tb_imu_fifo_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imu_fifo_arbiter.sv
// rtl/imu_fifo_arbiter.sv - round-robin burst arbiter sharing one IMU FIFO write port
module imu_fifo_arbiter #(
   parameter  int N_SRC     = 3,
   parameter  int WIDTH     = 64,
   parameter  int MAX_BURST = 4,
   localparam int ID_W      = $clog2(N_SRC)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_SRC-1:0]       src_valid,
   input  logic [N_SRC*WIDTH-1:0] src_data,
   output logic [N_SRC-1:0]       src_ready,
   input  logic                   fifo_full,
   output logic                   fifo_write_en,
   output logic [WIDTH-1:0]       fifo_data,
   output logic [ID_W-1:0]        fifo_src_id,
   output logic [N_SRC-1:0]       grant,
   output logic                   busy,
   output logic [15:0]            stall_cnt
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_LOCK = 1'b1
   } state_t;

   localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

   state_t            state_q;
   logic [N_SRC-1:0]  grant_q;
   logic [ID_W-1:0]   rr_ptr_q;
   logic [7:0]        beat_cnt_q;
   logic [15:0]       stall_cnt_q;

   logic              arb_found_d;
   logic [ID_W-1:0]   arb_win_d;
   logic [N_SRC-1:0]  arb_grant_d;
   logic [ID_W:0]     cand;
   logic              cur_valid;
   logic              xfer;

   // In LOCK rr_ptr_q always holds the granted index, so it doubles as g.
   assign busy          = (state_q == S_LOCK);
   assign grant         = grant_q;
   assign stall_cnt     = stall_cnt_q;
   assign cur_valid     = src_valid[rr_ptr_q];
   assign xfer          = busy & cur_valid & ~fifo_full;
   assign fifo_write_en = xfer;
   assign src_ready     = grant_q & {N_SRC{~fifo_full}};
   assign fifo_src_id   = busy ? rr_ptr_q : '0;

   // Round-robin search starting one past the last granted source, wrapping.
   always_comb begin
      arb_found_d = 1'b0;
      arb_win_d   = '0;
      arb_grant_d = '0;
      cand        = '0;
      for (int k = 1; k <= N_SRC; k++) begin
         cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(N_SRC)) begin
            cand = cand - (ID_W+1)'(N_SRC);
         end
         if (!arb_found_d && src_valid[cand[ID_W-1:0]]) begin
            arb_found_d = 1'b1;
            arb_win_d   = cand[ID_W-1:0];
         end
      end
      if (arb_found_d) begin
         arb_grant_d[arb_win_d] = 1'b1;
      end
   end

   // Data mux from the granted source; zero whenever no grant is held.
   always_comb begin
      fifo_data = '0;
      if (busy) begin
         for (int i = 0; i < N_SRC; i++) begin
            if (rr_ptr_q == ID_W'(i)) begin
               fifo_data = src_data[i*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Grant FSM: arbitrate when idle or on release, hold through full stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= ID_W'(N_SRC - 1);
         beat_cnt_q  <= 8'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               beat_cnt_q <= 8'd0;
               grant_q    <= arb_grant_d;
               if (arb_found_d) begin
                  state_q  <= S_LOCK;
                  rr_ptr_q <= arb_win_d;
               end
            end
            S_LOCK: begin
               if (!cur_valid || (xfer && beat_cnt_q == LAST_BEAT)) begin
                  // Release: the just-served source is searched last.
                  beat_cnt_q <= 8'd0;
                  grant_q    <= arb_grant_d;
                  if (arb_found_d) begin
                     rr_ptr_q <= arb_win_d;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else if (fifo_full) begin
                  if (stall_cnt_q != 16'hFFFF) begin
                     stall_cnt_q <= stall_cnt_q + 16'd1;
                  end
               end else begin
                  beat_cnt_q <= beat_cnt_q + 8'd1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imu_fifo_arbiter.sv
// tb/tb_imu_fifo_arbiter.sv - self-checking bench for imu_fifo_arbiter
module tb_imu_fifo_arbiter;

   localparam int N  = 3;
   localparam int W  = 64;
   localparam int MB = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [N-1:0]   src_valid = '0;
   logic [N*W-1:0] src_data = '0;
   logic           fifo_full = 1'b0;
   logic [N-1:0]   src_ready;
   logic           fifo_write_en;
   logic [W-1:0]   fifo_data;
   logic [1:0]     fifo_src_id;
   logic [N-1:0]   grant;
   logic           busy;
   logic [15:0]    stall_cnt;

   imu_fifo_arbiter #(.N_SRC(N), .WIDTH(W), .MAX_BURST(MB)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .src_valid    (src_valid),
      .src_data     (src_data),
      .src_ready    (src_ready),
      .fifo_full    (fifo_full),
      .fifo_write_en(fifo_write_en),
      .fifo_data    (fifo_data),
      .fifo_src_id  (fifo_src_id),
      .grant        (grant),
      .busy         (busy),
      .stall_cnt    (stall_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Reference model: owner index (-1 = nobody), last winner, beats done, stalls.
   int m_own = -1;
   int m_last = N - 1;
   int m_beats = 0;
   int m_stall = 0;

   int wq[$];
   int wcyc[$];
   logic [N-1:0] acc_last = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   function automatic int pick(input int last, input logic [N-1:0] v);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   // Compare DUT against the model on every falling edge, advance model on rising edge.
   always begin
      int n_own, n_last, n_beats, n_stall, w;
      logic do_arb;
      logic [N-1:0] e_grant, e_ready;
      logic e_busy, e_we;
      logic [W-1:0] e_data;
      logic [1:0] e_id;
      @(negedge clk);
      e_grant = '0; e_ready = '0; e_busy = 1'b0; e_we = 1'b0; e_data = '0; e_id = '0;
      n_own = m_own; n_last = m_last; n_beats = m_beats; n_stall = m_stall;
      do_arb = 1'b0;
      if (!rst_n) begin
         n_own = -1; n_last = N - 1; n_beats = 0; n_stall = 0;
         m_stall = 0; m_own = -1;
      end else begin
         if (m_own >= 0) begin
            e_busy = 1'b1;
            e_grant[m_own] = 1'b1;
            e_ready = fifo_full ? '0 : e_grant;
            e_we = src_valid[m_own] && !fifo_full;
            e_data = src_data[m_own*W +: W];
            e_id = 2'(m_own);
         end
         if (m_own < 0) do_arb = 1'b1;
         else if (!src_valid[m_own]) do_arb = 1'b1;
         else if (fifo_full) begin
            if (n_stall < 65535) n_stall = n_stall + 1;
         end else begin
            n_beats = m_beats + 1;
            if (n_beats == MB) do_arb = 1'b1;
         end
         if (do_arb) begin
            w = pick(m_last, src_valid);
            n_beats = 0;
            if (w >= 0) begin
               n_own = w;
               n_last = w;
            end else begin
               n_own = -1;
            end
         end
      end
      chk("grant", 64'(grant), 64'(e_grant));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("write_en", 64'(fifo_write_en), 64'(e_we));
      chk("src_ready", 64'(src_ready), 64'(e_ready));
      chk("fifo_data", fifo_data, e_data);
      chk("src_id", 64'(fifo_src_id), 64'(e_id));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      acc_last = src_valid & src_ready;
      if (e_we) begin
         wq.push_back(m_own);
         wcyc.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         m_own = -1; m_last = N - 1; m_beats = 0; m_stall = 0;
      end else begin
         m_own = n_own; m_last = n_last; m_beats = n_beats; m_stall = n_stall;
      end
   end

   // Advance one clock; accepted sources present a fresh sample.
   task automatic cycle();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc_last[i]) src_data[i*W +: W] = {$urandom, $urandom};
      end
   endtask

   task automatic wait_writes(input int n, input int bound, input string nm);
      int t;
      int target;
      t = 0;
      target = wq.size() + n;
      while (wq.size() < target && t < bound) begin
         cycle();
         t++;
      end
      chk(nm, 64'(wq.size() >= target), 64'd1);
   endtask

   task automatic do_reset();
      src_valid = '0;
      fifo_full = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle();
   endtask

   initial begin
      int start, cv, bad, s0;
      for (int i = 0; i < N; i++) src_data[i*W +: W] = {$urandom, $urandom};
      #2;
      do_reset();
      chk("reset_grant", 64'(grant), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_stall", 64'(stall_cnt), 64'd0);

      // Reset priority, continuous round robin
      start = wq.size();
      src_valid = 3'b111;
      wait_writes(13, 60, "prio_timeout");
      if (wq.size() >= start + 13) begin
         int exp_seq[13] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
         for (int i = 0; i < 13; i++) chk("prio_seq", 64'(wq[start+i]), 64'(exp_seq[i]));
         chk("prio_gapless", 64'(wcyc[start+12] - wcyc[start]), 64'd12);
      end

      // Single source, self-handover without a dead cycle
      do_reset();
      start = wq.size();
      cv = cyc;
      src_valid = 3'b100;
      wait_writes(10, 40, "single_timeout");
      if (wq.size() >= start + 10) begin
         bad = 0;
         for (int i = 0; i < 10; i++) if (wq[start+i] != 2) bad++;
         chk("single_ids", 64'(bad), 64'd0);
         chk("single_latency", 64'(wcyc[start] - cv), 64'd1);
         chk("single_span", 64'(wcyc[start+9] - wcyc[start]), 64'd9);
      end

      // Full stall mid-burst on source 1
      do_reset();
      src_valid = 3'b010;
      wait_writes(2, 20, "stall_timeout");
      fifo_full = 1'b1;
      src_valid = 3'b011;
      s0 = int'(stall_cnt);
      start = wq.size();
      repeat (5) cycle();
      chk("stall_nowrite", 64'(wq.size() - start), 64'd0);
      chk("stall_delta", 64'(int'(stall_cnt) - s0), 64'd5);
      fifo_full = 1'b0;
      wait_writes(6, 30, "resume_timeout");
      if (wq.size() >= start + 6) begin
         int exp_r[6] = '{1, 1, 0, 0, 0, 0};
         for (int i = 0; i < 6; i++) chk("resume_seq", 64'(wq[start+i]), 64'(exp_r[i]));
      end

      // Early release of source 0
      do_reset();
      start = wq.size();
      src_valid = 3'b111;
      wait_writes(2, 20, "early_timeout");
      src_valid[0] = 1'b0;
      cycle();
      src_valid[0] = 1'b1;
      wait_writes(9, 40, "early_rest_timeout");
      if (wq.size() >= start + 11) begin
         int exp_e[11] = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
         for (int i = 0; i < 11; i++) chk("early_seq", 64'(wq[start+i]), 64'(exp_e[i]));
      end

      // Asynchronous reset during beat 2 of source 1
      do_reset();
      src_valid = 3'b010;
      wait_writes(1, 20, "rstmid_timeout");
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_grant", 64'(grant), 64'd0);
      chk("rstmid_busy", 64'(busy), 64'd0);
      chk("rstmid_we", 64'(fifo_write_en), 64'd0);
      src_valid = 3'b111;
      cycle();
      #2;
      rst_n = 1'b1;
      start = wq.size();
      wait_writes(1, 20, "rstmid_regrant_timeout");
      if (wq.size() > start) chk("rstmid_first", 64'(wq[start]), 64'd0);

      // Randomized traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         cycle();
         fifo_full = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < N; i++) begin
            if (!src_valid[i] || acc_last[i]) begin
               src_valid[i] = ($urandom_range(0, 99) < 55);
               src_data[i*W +: W] = {$urandom, $urandom};
            end
         end
      end

      // Stall counter saturation
      do_reset();
      src_valid = 3'b001;
      fifo_full = 1'b1;
      repeat (65600) cycle();
      chk("sat_stall", 64'(stall_cnt), 64'hFFFF);
      chk("sat_busy", 64'(busy), 64'd1);
      chk("sat_we", 64'(fifo_write_en), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
